muldiv_unit: RTL and testbench

- Iterative multiply/divide responder for the multi-cycle 54-instruction CPU.
- Accepts the controller's mul_start/mulu_start/div_start/divu_start strobes with operands Rs/Rt.
- Holds busy while computing; the controller stalls on busy, then moves HI/LO into the hi/lo registers.
- Implements MIPS mult, multu, div and divu with a shift-add / restoring-division datapath, one bit per cycle.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_sign_fix.sv | 33 +++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encoding, FSM state encoding and default widths.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_CNT_W = 5;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   function automatic logic is_div_op(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction of a magnitude result.
// Multiply: the whole 2W-bit product is negated when the signs differed.
// Divide: the quotient (low half) follows sign_q, the remainder (high half)
// follows the dividend sign sign_r.
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic                 sign_q,
   input  logic                 sign_r,
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   raw,
   output logic [WIDTH-1:0]     hi,
   output logic [WIDTH-1:0]     lo
);

   logic [2*WIDTH-1:0] prod_fixed;

   assign prod_fixed = sign_q ? -raw : raw;

   // Select per-half negation for divide or whole-product negation for multiply
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
      hi = prod_fixed[2*WIDTH-1:WIDTH];
      lo = prod_fixed[WIDTH-1:0];
      if (is_div) begin
         lo = sign_q ? -raw[WIDTH-1:0]       : raw[WIDTH-1:0];
         hi = sign_r ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit, one result bit per cycle.
// Sequence: IDLE (accept start) -> CALC (WIDTH steps) -> FIX (sign fix,
// write hi/lo) -> IDLE with a one-cycle done pulse.
// A single 2W-bit accumulator serves both operations:
//   multiply: {partial product, multiplier}, shifted right each step;
//   divide:   {remainder, dividend/quotient}, shifted left each step.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = MD_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mul_start,
   input  logic             mulu_start,
   input  logic             div_start,
   input  logic             divu_start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [1:0]           op_q;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     opnd_q;    // multiplicand or divisor magnitude
   logic                 sign_q;
   logic                 sign_r;
   logic                 dz_q;

   logic                 any_start;
   logic [1:0]           start_op;
   logic                 start_signed;
   logic                 start_is_div;
   logic                 a_neg;
   logic                 b_neg;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;

   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       rem_sh;
   logic                 div_ok;
   logic [WIDTH-1:0]     div_rem;
   logic [2*WIDTH-1:0]   step_next;

   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;

   assign any_start = div_start | divu_start | mul_start | mulu_start;
   assign busy      = (state != ST_IDLE) | any_start;

   // Resolve simultaneous strobes: div > divu > mul > mulu
   always_comb begin
      start_op = OP_MULTU;
      if (div_start)
         start_op = OP_DIV;
      else if (divu_start)
         start_op = OP_DIVU;
      else if (mul_start)
         start_op = OP_MULT;
   end

   assign start_signed = (start_op == OP_MULT) || (start_op == OP_DIV);
   assign start_is_div = is_div_op(start_op);
   assign a_neg        = start_signed & a[WIDTH-1];
   assign b_neg        = start_signed & b[WIDTH-1];
   assign a_mag        = a_neg ? -a : a;
   assign b_mag        = b_neg ? -b : b;

   // One shift-add or restoring-division step on the accumulator
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
      rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ok    = rem_sh >= {1'b0, opnd_q};
      div_rem   = rem_sh[WIDTH-1:0] - opnd_q;
      step_next = {mul_sum, acc[WIDTH-1:1]};
      if (is_div_op(op_q))
         step_next = {(div_ok ? div_rem : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};
   end

   muldiv_sign_fix #(
      .WIDTH (WIDTH)
   ) u_sign_fix (
      .sign_q (sign_q),
      .sign_r (sign_r),
      .is_div (is_div_op(op_q)),
      .raw    (acc),
      .hi     (fix_hi),
      .lo     (fix_lo)
   );

   // Control FSM with iteration counter, datapath registers and result outputs
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_q     <= OP_MULT;
         acc      <= '0;
         opnd_q   <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         dz_q     <= 1'b0;
         busy_unused_guard: begin end
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_start) begin
                  op_q     <= start_op;
                  cnt      <= '0;
                  div_zero <= 1'b0;
                  dz_q     <= start_is_div && (b == '0);
                  sign_r   <= a_neg;
                  // With a zero divisor the quotient must stay all ones, so it
                  // is never negated; the remainder path still restores a.
                  sign_q   <= (a_neg ^ b_neg) & ~(start_is_div && (b == '0));
                  if (start_is_div) begin
                     acc    <= {{WIDTH{1'b0}}, a_mag};
                     opnd_q <= b_mag;
                  end else begin
                     acc    <= {{WIDTH{1'b0}}, b_mag};
                     opnd_q <= a_mag;
                  end
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               acc <= step_next;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1))
                  state <= ST_FIX;
            end
            ST_FIX: begin
               hi       <= fix_hi;
               lo       <= fix_lo;
               div_zero <= dz_q;
               done     <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected results are queued when an
// operation is issued and compared when done pulses.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mul_start = 1'b0;
   logic          mulu_start = 1'b0;
   logic          div_start = 1'b0;
   logic          divu_start = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          div_zero;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .mul_start  (mul_start),
      .mulu_start (mulu_start),
      .div_start  (div_start),
      .divu_start (divu_start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] h, input logic [W-1:0] l, input logic dz);
      exp_t e;
      e.hi = h;
      e.lo = l;
      e.dz = dz;
      return e;
   endfunction

   // Reference behaviour from plain 64-bit arithmetic
   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t        e;
      longint      sa;
      longint      sbv;
      longint      q;
      longint      r;
      logic [63:0] p;
      sa  = longint'($signed(av));
      sbv = longint'($signed(bv));
      e   = '0;
      case (op)
         OP_MULT: begin
            p    = 64'(sa * sbv);
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         OP_MULTU: begin
            p    = {32'b0, av} * {32'b0, bv};
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         OP_DIV: begin
            if (bv == '0) begin
               e = mk(av, '1, 1'b1);
            end else begin
               q    = sa / sbv;
               r    = sa % sbv;
               e.lo = q[31:0];
               e.hi = r[31:0];
            end
         end
         default: begin
            if (bv == '0)
               e = mk(av, '1, 1'b1);
            else
               e = mk(av % bv, av / bv, 1'b0);
         end
      endcase
      return e;
   endfunction

   function automatic logic [3:0] starts_of(input logic [1:0] op);
      case (op)
         OP_DIV:  return 4'b1000;
         OP_DIVU: return 4'b0100;
         OP_MULT: return 4'b0010;
         default: return 4'b0001;
      endcase
   endfunction

   // Compare every completion against the oldest queued expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 64'(done), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("div_zero", 64'(div_zero), 64'(e.dz));
         end
      end
   end

   // Drive start strobes for one cycle; returns one cycle after the start cycle
   task automatic issue(input logic [3:0] st, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input exp_t e, input bit push);
      {div_start, divu_start, mul_start, mulu_start} = st;
      a = av;
      b = bv;
      if (push)
         sb.push_back(e);
      #1;
      chk("busy_on_start", 64'(busy), 64'd1);
      @(negedge clk);
      #1;
      {div_start, divu_start, mul_start, mulu_start} = 4'b0000;
      a = $urandom;
      b = $urandom;
   endtask

   // Wait (bounded) for done and measure how long busy stayed high
   task automatic wait_done(input bit check_len);
      int n;
      n = 1;
      forever begin
         if (done)
            break;
         if (busy)
            n++;
         if (n > 100) begin
            chk("done_timeout", 64'(n), 64'(W + 2));
            break;
         end
         @(negedge clk);
         #1;
      end
      if (check_len && done)
         chk("busy_len", 64'(n), 64'(W + 2));
   endtask

   task automatic run(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input exp_t e);
      issue(starts_of(op), av, bv, e, 1'b1);
      wait_done(1'b1);
   endtask

   task automatic run_model(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
      run(op, av, bv, model(op, av, bv));
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [1:0]   op;
      logic [W-1:0] av;
      logic [W-1:0] bv;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_div_zero", 64'(div_zero), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      #1;

      // Directed vectors
      run(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, mk(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0));
      run(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, mk(32'h0000_0001, 32'hFFFF_FFFE, 1'b0));
      run(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
      run(OP_DIVU,  32'd100,       32'd7,         mk(32'd2, 32'd14, 1'b0));
      run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0000_0000, 32'h8000_0000, 1'b0));
      run(OP_DIV,   32'h1234_5678, 32'h0000_0000, mk(32'h1234_5678, 32'hFFFF_FFFF, 1'b1));

      // div_zero drops as soon as the next operation is accepted
      issue(starts_of(OP_MULTU), 32'd3, 32'd5, mk(32'd0, 32'd15, 1'b0), 1'b1);
      chk("div_zero_cleared", 64'(div_zero), 64'd0);
      wait_done(1'b1);

      // Simultaneous div and mul strobes: divide wins (200 / 9 = 22 r 2)
      issue(4'b1010, 32'd200, 32'd9, mk(32'd2, 32'd22, 1'b0), 1'b1);
      wait_done(1'b1);

      // mulu strobe while busy must be ignored (1000 / 33 = 30 r 10)
      issue(starts_of(OP_DIVU), 32'd1000, 32'd33, mk(32'd10, 32'd30, 1'b0), 1'b1);
      fork
         wait_done(1'b1);
         begin
            repeat (5) @(negedge clk);
            #2;
            mulu_start = 1'b1;
            @(negedge clk);
            #2;
            mulu_start = 1'b0;
         end
      join

      // Sign and range corners
      run_model(OP_MULT, 32'h8000_0000, 32'h8000_0000);
      run_model(OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE);
      run_model(OP_DIV,  32'd7,         32'hFFFF_FFFE);
      run_model(OP_DIVU, 32'hFFFF_FFFF, 32'd2);
      run_model(OP_DIVU, 32'd5,         32'd0);
      run_model(OP_DIV,  32'hFFFF_FFF0, 32'd0);

      // Random operations, some with tiny or zero divisors
      for (int i = 0; i < 10; i++) begin
         op = 2'($urandom_range(0, 3));
         av = $urandom;
         bv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
         run_model(op, av, bv);
      end

      // Leave non-zero hi/lo, then reset in the middle of CALC
      run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
      issue(starts_of(OP_MULTU), 32'd1234, 32'd5678, mk(32'd0, 32'd0, 1'b0), 1'b0);
      repeat (9) @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      chk("midrst_div_zero", 64'(div_zero), 64'd0);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      chk("midrst_idle_busy", 64'(busy), 64'd0);

      // Recovery after reset
      run(OP_MULTU, 32'd3, 32'd5, mk(32'd0, 32'd15, 1'b0));

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
